// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB arbiter: state encoding, default widths, error codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_arb_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Value returned on mN_pslverr
    localparam logic ERR_OK      = 1'b0;
    localparam logic ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way round-robin picker: grants the requester that did not win last time when both ask.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when to consume the pick.
// Ports: req[1:0] pending requests, last_grant previous winner -> valid any request, winner index.
module apb_rr_pick
    import apb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else begin
            // single requester (or none): index of the set bit
            winner = req[1];
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB slave bus between requesters m0/m1, round-robin, one registered transfer at a time.
// Latency: request seen in IDLE at n -> s_psel n+1, s_penable n+2, requester pready one cycle after s_pready.
// Backpressure: losing requester waits with pready low; slave stalls via s_pready, bounded by the watchdog.
// Ports: m0_*/m1_* requester APB slave ports, s_* shared APB master port,
//        busy (not IDLE), grant (current/last owner), timeout_pulse (watchdog expiry).
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,
    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic              s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    output logic [ADDR_W-1:0] s_paddr,
    output logic [DATA_W-1:0] s_pwdata,
    input  logic [DATA_W-1:0] s_prdata,
    input  logic              s_pready,
    output logic              busy,
    output logic              grant,
    output logic              timeout_pulse
);

    // Last ACCESS cycle index before the watchdog fires; unused when TIMEOUT is 0
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            state, state_nxt;
    logic              last_grant;
    logic              grant_nxt;
    logic [TO_W-1:0]   cnt, cnt_nxt;
    logic              load;
    logic              to_fire;
    logic [DATA_W-1:0] rsp_dat;
    logic              rsp_err;
    logic              rsp0, rsp1;
    logic              pick_vld, pick_winner;

    // Requests are recognised by psel alone, in either phase
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    apb_rr_pick u_pick (
        .req        ({m1_psel, m0_psel}),
        .last_grant (last_grant),
        .valid      (pick_vld),
        .winner     (pick_winner)
    );

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        cnt_nxt   = cnt;
        load      = 1'b0;
        to_fire   = 1'b0;
        rsp_dat   = '0;
        rsp_err   = ERR_OK;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    load      = 1'b1;
                    grant_nxt = pick_winner;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cnt_nxt   = '0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                // s_pready takes priority over a watchdog expiry in the same cycle
                if (s_pready) begin
                    rsp_dat   = s_pwrite ? '0 : s_prdata;
                    rsp_err   = ERR_OK;
                    state_nxt = RESP;
                end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                    rsp_dat   = '0;
                    rsp_err   = ERR_TIMEOUT;
                    to_fire   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Response is loaded only on the ACCESS->RESP edge and cleared on the next edge
    assign rsp0 = (state_nxt == RESP) && (grant_nxt == 1'b0);
    assign rsp1 = (state_nxt == RESP) && (grant_nxt == 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= '0;
            s_psel        <= 1'b0;
            s_penable     <= 1'b0;
            s_pwrite      <= 1'b0;
            s_paddr       <= '0;
            s_pwdata      <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            m0_pready     <= 1'b0;
            m0_prdata     <= '0;
            m0_pslverr    <= 1'b0;
            m1_pready     <= 1'b0;
            m1_prdata     <= '0;
            m1_pslverr    <= 1'b0;
        end else begin
            state         <= state_nxt;
            grant         <= grant_nxt;
            cnt           <= cnt_nxt;
            s_psel        <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            s_penable     <= (state_nxt == ACCESS);
            busy          <= (state_nxt != IDLE);
            timeout_pulse <= to_fire;
            m0_pready     <= rsp0;
            m0_prdata     <= rsp0 ? rsp_dat : '0;
            m0_pslverr    <= rsp0 ? rsp_err : 1'b0;
            m1_pready     <= rsp1;
            m1_prdata     <= rsp1 ? rsp_dat : '0;
            m1_pslverr    <= rsp1 ? rsp_err : 1'b0;
            if (load) begin
                last_grant <= pick_winner;
                s_pwrite   <= pick_winner ? m1_pwrite : m0_pwrite;
                s_paddr    <= pick_winner ? m1_paddr  : m0_paddr;
                s_pwdata   <= pick_winner ? m1_pwdata : m0_pwdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk, rst_n;
    logic          m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
    logic [AW-1:0] m0_paddr;
    logic [DW-1:0] m0_pwdata, m0_prdata;
    logic          m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
    logic [AW-1:0] m1_paddr;
    logic [DW-1:0] m1_pwdata, m1_prdata;
    logic          s_psel, s_penable, s_pwrite, s_pready;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata, s_prdata;
    logic          busy, grant, timeout_pulse;

    apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata),
        .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata),
        .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready),
        .busy(busy), .grant(grant), .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit m; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] rdata; int wait_n; } slv_t;
    typedef struct { bit m; logic [DW-1:0] rdata; bit err; } rsp_t;
    typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;

    slv_t exp_slv[$];
    rsp_t exp_rsp[$];
    req_t req_q0[$];
    req_t req_q1[$];

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, acc_n = 0, last_acc_n = 0, to_cnt = 0, setup_cyc = 0;
    int   setup_m[2], access_m[2], rsp_m[2], start_m[2];
    bit   act0 = 0, act1 = 0, rs0 = 0, rs1 = 0, cur_vld = 0;
    slv_t cur;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Queue one request and its expected slave transfer and response (in expected grant order)
    task automatic issue(input bit m, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd, input int wt);
        req_t q; slv_t s; rsp_t r;
        q.wr = wr; q.addr = a; q.wdata = wd;
        if (m) req_q1.push_back(q); else req_q0.push_back(q);
        s.m = m; s.wr = wr; s.addr = a; s.wdata = wd; s.rdata = rd; s.wait_n = wt;
        exp_slv.push_back(s);
        r.m = m;
        if (wt < 0 || wt >= TO) begin r.rdata = '0; r.err = 1'b1; end
        else begin r.rdata = wr ? '0 : rd; r.err = 1'b0; end
        exp_rsp.push_back(r);
    endtask

    task automatic monitor();
        rsp_t e; bit m;
        rs0 = 0; rs1 = 0;
        if (timeout_pulse) to_cnt++;
        if (s_psel && !s_penable) setup_cyc = cyc;
        if (m0_pready || m1_pready) begin
            m = m1_pready;
            check_eq("rsp_one_hot", {m0_pready, m1_pready} == 2'b11, 0);
            check_eq("rsp_expected", exp_rsp.size() != 0, 1);
            if (exp_rsp.size() != 0) begin
                e = exp_rsp.pop_front();
                check_eq("rsp_who", m, e.m);
                check_eq("rsp_rdata", m ? m1_prdata : m0_prdata, e.rdata);
                check_eq("rsp_err", m ? m1_pslverr : m0_pslverr, e.err);
                check_eq("rsp_to_pulse", timeout_pulse, e.err);
            end
            check_eq("rsp_other_quiet",
                     m ? {m0_pready, m0_pslverr, m0_prdata} : {m1_pready, m1_pslverr, m1_prdata}, 0);
            rsp_m[m] = cyc;
            if (m) rs1 = 1; else rs0 = 1;
        end
    endtask

    task automatic drive_slave();
        if (s_psel && s_penable) begin
            if (acc_n == 0) begin
                check_eq("slv_expected", exp_slv.size() != 0, 1);
                cur_vld = (exp_slv.size() != 0);
                if (cur_vld) begin
                    cur = exp_slv.pop_front();
                    check_eq("slv_grant", grant, cur.m);
                    check_eq("slv_write", s_pwrite, cur.wr);
                    check_eq("slv_addr", s_paddr, cur.addr);
                    if (cur.wr) check_eq("slv_wdata", s_pwdata, cur.wdata);
                    check_eq("slv_busy", busy, 1);
                    setup_m[cur.m]  = setup_cyc;
                    access_m[cur.m] = cyc;
                end
            end
            acc_n++;
            s_pready = cur_vld && cur.wait_n >= 0 && acc_n == cur.wait_n + 1;
            s_prdata = cur_vld ? cur.rdata : 32'hBAD0_BAD0;
        end else begin
            if (acc_n != 0) last_acc_n = acc_n;
            acc_n = 0;
            // junk outside ACCESS; the arbiter must ignore it
            s_pready = 1'b1;
            s_prdata = 32'hFFFF_0000 ^ 32'(cyc);
        end
    endtask

    task automatic drive_req();
        if (rs0) begin if (req_q0.size() != 0) req_q0.delete(0); act0 = 0; end
        if (!act0 && req_q0.size() != 0) begin
            m0_psel = 1; m0_penable = 0; m0_pwrite = req_q0[0].wr;
            m0_paddr = req_q0[0].addr; m0_pwdata = req_q0[0].wdata; act0 = 1; start_m[0] = cyc;
        end else if (act0) m0_penable = 1;
        else begin m0_psel = 0; m0_penable = 0; end
        if (rs1) begin if (req_q1.size() != 0) req_q1.delete(0); act1 = 0; end
        if (!act1 && req_q1.size() != 0) begin
            m1_psel = 1; m1_penable = 0; m1_pwrite = req_q1[0].wr;
            m1_paddr = req_q1[0].addr; m1_pwdata = req_q1[0].wdata; act1 = 1; start_m[1] = cyc;
        end else if (act1) m1_penable = 1;
        else begin m1_psel = 0; m1_penable = 0; end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        monitor();
        drive_slave();
        drive_req();
    endtask

    task automatic flush();
        exp_slv.delete(); exp_rsp.delete(); req_q0.delete(); req_q1.delete();
        act0 = 0; act1 = 0; cur_vld = 0; acc_n = 0;
        m0_psel = 0; m0_penable = 0; m1_psel = 0; m1_penable = 0;
    endtask

    task automatic run_idle(input int budget, input string tag);
        int  k;
        bit  done;
        k = 0; done = 0;
        while (!done && k < budget) begin
            tick(); k++;
            done = exp_rsp.size() == 0 && exp_slv.size() == 0 && req_q0.size() == 0 &&
                   req_q1.size() == 0 && !busy && !act0 && !act1;
        end
        check_eq({tag, "_done"}, done, 1);
        if (!done) flush();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int to0, k;
        rst_n = 0;
        m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = '0; m0_pwdata = '0;
        m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = '0; m1_pwdata = '0;
        s_pready = 0; s_prdata = '0;
        repeat (3) tick();
        check_eq("rst_ctrl", {s_psel, s_penable, busy, grant, timeout_pulse}, 0);
        check_eq("rst_rsp", {m0_pready, m1_pready, m0_pslverr, m1_pslverr}, 0);
        check_eq("rst_addr", s_paddr, 0);
        rst_n = 1;
        tick();

        // Simultaneous reads after reset: m0 first, m1 SETUP two cycles after m0 RESP
        issue(0, 0, 20'h00011, '0, 32'h11, 0);
        issue(1, 0, 20'h00022, '0, 32'h22, 0);
        run_idle(60, "t2");
        check_eq("t2_gap", setup_m[1] - rsp_m[0], 2);

        // Single write, latency from request
        issue(0, 1, 20'h00104, 32'hDEAD_BEEF, 32'h0, 0);
        run_idle(40, "t1");
        check_eq("t1_setup_lat", setup_m[0] - start_m[0], 1);
        check_eq("t1_access_lat", access_m[0] - start_m[0], 2);
        check_eq("t1_rsp_lat", rsp_m[0] - start_m[0], 3);
        check_eq("t1_grant", grant, 0);

        // Both hold requests; last grant was m0, so m1 leads and grants alternate
        for (int i = 0; i < 3; i++) begin
            issue(1, 0, AW'(20'h00300 + i), '0, 32'hB000_0000 + 32'(i), i);
            issue(0, 0, AW'(20'h00200 + i), '0, 32'hA000_0000 + 32'(i), 2 - i);
        end
        run_idle(200, "t3");

        // Watchdog expiry: exactly TO ACCESS cycles, one pulse, error response
        to0 = to_cnt;
        issue(1, 0, 20'h00400, '0, 32'h1234_5678, -1);
        run_idle(60, "t4");
        check_eq("t4_pulses", to_cnt - to0, 1);
        check_eq("t4_access_cycles", last_acc_n, TO);
        check_eq("t4_grant", grant, 1);
        check_eq("t4_idle", {busy, s_psel, s_penable}, 0);

        // pready on the expiry cycle wins
        to0 = to_cnt;
        issue(1, 0, 20'h00500, '0, 32'h5555_AAAA, TO - 1);
        run_idle(60, "t5");
        check_eq("t5_pulses", to_cnt - to0, 0);
        check_eq("t5_access_cycles", last_acc_n, TO);

        // Reset during ACCESS, then m0 wins the tie again
        issue(0, 0, 20'h00600, '0, 32'h0, -1);
        k = 0;
        while (!(s_psel && s_penable && acc_n == 2) && k < 20) begin tick(); k++; end
        check_eq("t6_reach_access", k < 20, 1);
        rst_n = 0;
        #1;
        check_eq("t6_async", {s_psel, s_penable, busy, m0_pready, m1_pready}, 0);
        flush();
        repeat (2) tick();
        rst_n = 1;
        issue(0, 0, 20'h00700, '0, 32'h7070_0000, 0);
        issue(1, 0, 20'h00701, '0, 32'h7171_0000, 1);
        run_idle(60, "t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB slave-side bus between two APB requesters, m0 and m1.
  - m0: the AXI-to-APB bridge path from the CPU.
  - m1: a debug or DMA APB master.
- Arbitration is round-robin, one transfer at a time, and the granted transfer is re-issued on the slave bus with registered address, control and data.
- A watchdog ends any slave access that never returns pready and reports an error to the requester.
- Sits between the bridge/debug masters and the APB address decoder.

Parameters:
ADDR_W, 20, APB address width
DATA_W, 32, APB data width
TIMEOUT, 255, max slave ACCESS cycles before forced termination; 0 disables the watchdog
TO_W, 8, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
m0_psel  in  1  requester 0 select
m0_penable  in  1  requester 0 enable
m0_pwrite  in  1  requester 0 write=1/read=0
m0_paddr  in  ADDR_W  requester 0 address
m0_pwdata  in  DATA_W  requester 0 write data
m0_prdata  out  DATA_W  requester 0 read data
m0_pready  out  1  requester 0 ready
m0_pslverr  out  1  requester 0 error
m1_psel, m1_penable, m1_pwrite, m1_paddr, m1_pwdata  in  as m0  requester 1 request
m1_prdata, m1_pready, m1_pslverr  out  as m0  requester 1 response
s_psel  out  1  slave-bus select
s_penable  out  1  slave-bus enable
s_pwrite  out  1  slave-bus direction
s_paddr  out  ADDR_W  slave-bus address
s_pwdata  out  DATA_W  slave-bus write data
s_prdata  in  DATA_W  slave-bus read data
s_pready  in  1  slave-bus ready
busy  out  1  arbiter not IDLE
grant  out  1  requester owning the current or last transfer (0/1)
timeout_pulse  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async, rst_n=0): all outputs drop to 0 immediately; state=IDLE; last_grant=1, so m0 wins the first tie; counter=0.
  - Any slave transfer in flight is abandoned with no response.
- Request: mN_psel=1, in either phase. Non-granted requesters see mN_pready=0 and wait in their access phase.
- FSM states (all outputs registered):
  - IDLE: if any request, pick a winner.
    - One requester: that one.
    - Both: the one != last_grant.
    - Latch winner's pwrite/paddr/pwdata; grant<=winner; last_grant<=winner; go SETUP.
  - SETUP: s_psel=1, s_penable=0; next cycle go ACCESS; clear counter.
  - ACCESS: s_psel=1, s_penable=1.
    - If s_pready: capture s_prdata (reads only; writes capture 0); err=0; go RESP.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1: rdata=0; err=1; timeout_pulse=1 for one cycle; go RESP.
    - Else counter+1.
    - Leaving ACCESS drops s_psel and s_penable in the same edge.
  - RESP: mG_pready=1 for exactly one cycle, where G=grant; mG_prdata=captured data; mG_pslverr=err; go IDLE.
    - The other requester's response outputs stay 0.
- Latency: request seen in IDLE at cycle n gives s_psel at n+1, s_penable at n+2; with s_pready at n+2, mG_pready at n+3.
  - Back-to-back: IDLE re-arbitrates the cycle after RESP.
  - A waiting requester gets SETUP 2 cycles after the previous RESP.
- mN_prdata and mN_pslverr are 0 whenever mN_pready=0.
- Requester deasserts psel mid-transfer (protocol violation): the slave transfer still completes and the RESP cycle still occurs.
  - The pready pulse is driven but ignored; no lockup.
- Slave inputs are ignored outside ACCESS.
- s_pready arriving on the same cycle as watchdog expiry: s_pready wins; no error, no pulse.
- busy=1 in SETUP, ACCESS and RESP.

Decomposition:
- Shared package apb_arb_pkg:
  - state encoding constants IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3;
  - default ADDR_W/DATA_W;
  - error code constants.
- One sub-module, apb_rr_pick:
  - combinational two-way round-robin picker;
  - inputs: req[1:0], last_grant; outputs: valid, winner.
  - Kept separate so it can be widened to N requesters later.
- The watchdog counter stays inline.

Test Plan:
- m0 write addr 0x00104, data 0xDEADBEEF, slave pready on first ACCESS cycle -> s_psel at n+1, s_penable at n+2, s_pwdata=0xDEADBEEF, m0_pready pulse at n+3, m0_pslverr=0, grant=0.
- m0 and m1 both request in the same cycle after reset, reads with s_prdata=0x11 then 0x22 -> m0 served first and gets 0x11; m1 served next and gets 0x22, its SETUP starting 2 cycles after m0's RESP.
- m1 holds its request continuously while m0 issues 3 back-to-back reads -> grants alternate 0,1,0,1; neither requester is starved.
- TIMEOUT=4, slave never raises pready on an m1 read -> exactly 4 ACCESS cycles, timeout_pulse once, m1_pready=1, m1_pslverr=1, m1_prdata=0, bus returns to IDLE.
- TIMEOUT=4, s_pready on the 4th ACCESS cycle -> normal completion, m1_pslverr=0, no timeout_pulse.
- rst_n pulsed low during ACCESS -> s_psel, s_penable, busy and all pready go 0 asynchronously; after release, an m0 request is granted first (last_grant=1).
